// File: rtl/writeback_stage.sv
// writeback_stage: aligns memory-stage results, buffers two of them, and drains them into the register file
module writeback_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic [4:0]      i_rd,
  input  logic            i_reg_write,
  input  logic            i_is_load,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  output logic            o_rf_we,
  output logic [4:0]      o_rf_rd,
  output logic [XLEN-1:0] o_rf_data,
  input  logic            i_rf_ack,
  output logic [63:0]     o_instret,
  output logic            o_empty
);
  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] data_q [2];
  logic [4:0] rd_q [2];
  logic we_q [2];
  logic wr_ptr, rd_ptr;
  logic [63:0] instret_q;
  logic enq, retire, head_valid, head_we;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [XLEN-1:0] aligned;
  assign byte_v = i_wb_data[{i_addr_lo, 3'b000} +: 8];
  assign half_v = i_wb_data[{i_addr_lo[1], 4'b0000} +: 16];
  assign o_ready = state != FULL;
  assign enq = i_valid && o_ready;
  assign head_valid = state != EMPTY;
  assign head_we = we_q[rd_ptr];
  assign o_rf_we = head_valid && head_we;
  assign retire = head_valid && (!head_we || i_rf_ack);
  assign o_rf_rd = o_rf_we ? rd_q[rd_ptr] : '0;
  assign o_rf_data = o_rf_we ? data_q[rd_ptr] : '0;
  assign o_instret = instret_q;
  assign o_empty = state == EMPTY;
  // load alignment: pick the addressed byte/half and extend it; anything else passes through
  always_comb begin
    aligned = i_wb_data;
    if (i_is_load)
      aligned = i_funct3 == 3'b000 ? {{(XLEN-8){byte_v[7]}}, byte_v} :
                i_funct3 == 3'b100 ? {{(XLEN-8){1'b0}}, byte_v} :
                i_funct3 == 3'b001 ? {{(XLEN-16){half_v[15]}}, half_v} :
                i_funct3 == 3'b101 ? {{(XLEN-16){1'b0}}, half_v} : i_wb_data;
  end
  // occupancy transitions; enqueue and retire together leave the count unchanged
  always_comb begin
    state_nx = state;
    if (enq && !retire) state_nx = state == EMPTY ? HALF : FULL;
    else if (retire && !enq) state_nx = state == FULL ? HALF : EMPTY;
  end
  // state register
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) state <= EMPTY;
    else state <= state_nx;
  // entry storage, pointers and retirement counter; rd 0 entries never write
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        rd_q[i] <= '0;
        we_q[i] <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      instret_q <= '0;
    end else begin
      if (enq) begin
        data_q[wr_ptr] <= aligned;
        rd_q[wr_ptr] <= i_rd;
        we_q[wr_ptr] <= i_reg_write && (i_rd != 5'd0);
        wr_ptr <= ~wr_ptr;
      end
      if (retire) begin
        rd_ptr <= ~rd_ptr;
        instret_q <= instret_q + 64'd1;
      end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed scoreboard bench for the writeback stage
module tb_writeback_stage;
  logic i_clk = 1'b0, i_reset = 1'b1, i_valid = 1'b0, o_ready;
  logic [31:0] i_wb_data = '0, o_rf_data;
  logic [4:0] i_rd = '0, o_rf_rd;
  logic i_reg_write = 1'b0, i_is_load = 1'b0, o_rf_we, i_rf_ack = 1'b0, o_empty;
  logic [2:0] i_funct3 = '0;
  logic [1:0] i_addr_lo = '0;
  logic [63:0] o_instret;
  typedef struct {logic [4:0] rd; logic [31:0] data;} exp_t;
  exp_t sb [$];
  int n_pass = 0, n_total = 0;
  logic [63:0] exp_ret = '0;

  writeback_stage #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_wb_data(i_wb_data), .i_rd(i_rd), .i_reg_write(i_reg_write), .i_is_load(i_is_load),
    .i_funct3(i_funct3), .i_addr_lo(i_addr_lo), .o_rf_we(o_rf_we), .o_rf_rd(o_rf_rd),
    .o_rf_data(o_rf_data), .i_rf_ack(i_rf_ack), .o_instret(o_instret), .o_empty(o_empty)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] align(input logic [31:0] d, input logic ld, input logic [2:0] f3, input logic [1:0] a);
    logic [7:0] b;
    logic [15:0] h;
    b = a == 2'd0 ? d[7:0] : a == 2'd1 ? d[15:8] : a == 2'd2 ? d[23:16] : d[31:24];
    h = a[1] ? d[31:16] : d[15:0];
    if (!ld) return d;
    case (f3)
      3'b000: return {{24{b[7]}}, b};
      3'b100: return {24'd0, b};
      3'b001: return {{16{h[15]}}, h};
      3'b101: return {16'd0, h};
      default: return d;
    endcase
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [4:0] rd, input logic rw, input logic ld, input logic [2:0] f3, input logic [1:0] a);
    i_valid = 1'b1; i_wb_data = d; i_rd = rd; i_reg_write = rw; i_is_load = ld; i_funct3 = f3; i_addr_lo = a;
    if (rw && rd != 5'd0) sb.push_back('{rd, align(d, ld, f3, a)});
    exp_ret++;
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] rd, input logic rw, input logic ld, input logic [2:0] f3, input logic [1:0] a);
    drive(d, rd, rw, ld, f3, a);
    step();
    i_valid = 1'b0;
  endtask

  // scoreboard: head must match the oldest expected write; it leaves the queue on ack
  always @(negedge i_clk)
    if (i_reset && o_rf_we) begin
      if (sb.size() == 0) chk("sb_spurious_write", 1, 0);
      else begin
        chk("sb_rd", 64'(o_rf_rd), 64'(sb[0].rd));
        chk("sb_data", 64'(o_rf_data), 64'(sb[0].data));
        if (i_rf_ack) void'(sb.pop_front());
      end
    end

  initial begin
    #1 i_reset = 1'b0;
    #1;
    chk("rst_we", 64'(o_rf_we), 0);
    chk("rst_rd", 64'(o_rf_rd), 0);
    chk("rst_data", 64'(o_rf_data), 0);
    chk("rst_instret", o_instret, 0);
    chk("rst_empty", 64'(o_empty), 1);
    chk("rst_ready", 64'(o_ready), 1);
    step();
    step();
    i_reset = 1'b1;
    i_rf_ack = 1'b1;
    send(32'h0000_8000, 5'd5, 1'b1, 1'b1, 3'b000, 2'd1);
    chk("lb_we", 64'(o_rf_we), 1);
    chk("lb_rd", 64'(o_rf_rd), 5);
    chk("lb_data", 64'(o_rf_data), 64'h0000_0000_FFFF_FF80);
    step();
    chk("lb_instret", o_instret, 1);
    chk("lb_empty", 64'(o_empty), 1);
    send(32'hBEEF_1234, 5'd6, 1'b1, 1'b1, 3'b101, 2'd2);
    chk("lhu_data", 64'(o_rf_data), 64'h0000_0000_0000_BEEF);
    send(32'h80F1_7F22, 5'd7, 1'b1, 1'b1, 3'b100, 2'd3);
    send(32'h80F1_7F22, 5'd8, 1'b1, 1'b1, 3'b000, 2'd3);
    send(32'h1234_8001, 5'd9, 1'b1, 1'b1, 3'b001, 2'd0);
    send(32'h1234_8001, 5'd10, 1'b1, 1'b1, 3'b001, 2'd2);
    send(32'hCAFE_F00D, 5'd11, 1'b1, 1'b1, 3'b010, 2'd0);
    send(32'hCAFE_F00D, 5'd12, 1'b1, 1'b1, 3'b011, 2'd1);
    send(32'hDEAD_BEEF, 5'd13, 1'b1, 1'b0, 3'b000, 2'd1);
    send(32'h5555_AAAA, 5'd14, 1'b0, 1'b1, 3'b000, 2'd0);
    step();
    chk("stream_instret", o_instret, exp_ret);
    chk("stream_empty", 64'(o_empty), 1);
    send(32'h1111_2222, 5'd0, 1'b1, 1'b0, 3'b000, 2'd0);
    chk("rd0_we", 64'(o_rf_we), 0);
    chk("rd0_empty", 64'(o_empty), 0);
    step();
    chk("rd0_instret", o_instret, exp_ret);
    i_rf_ack = 1'b0;
    send(32'hAAAA_0001, 5'd7, 1'b1, 1'b0, 3'b000, 2'd0);
    chk("bp_ready1", 64'(o_ready), 1);
    send(32'hBBBB_0002, 5'd8, 1'b1, 1'b0, 3'b000, 2'd0);
    chk("bp_ready2", 64'(o_ready), 0);
    drive(32'hCCCC_0003, 5'd9, 1'b1, 1'b0, 3'b000, 2'd0);
    step();
    chk("bp_full_ready", 64'(o_ready), 0);
    chk("bp_hold_data", 64'(o_rf_data), 64'h0000_0000_AAAA_0001);
    chk("bp_hold_rd", 64'(o_rf_rd), 7);
    step();
    chk("bp_hold_data2", 64'(o_rf_data), 64'h0000_0000_AAAA_0001);
    i_rf_ack = 1'b1;
    step();
    chk("bp_second", 64'(o_rf_data), 64'h0000_0000_BBBB_0002);
    chk("bp_ready3", 64'(o_ready), 1);
    step();
    chk("bp_third", 64'(o_rf_data), 64'h0000_0000_CCCC_0003);
    i_valid = 1'b0;
    step();
    chk("bp_empty", 64'(o_empty), 1);
    chk("bp_instret", o_instret, exp_ret);
    i_rf_ack = 1'b0;
    send(32'hDDDD_0004, 5'd3, 1'b1, 1'b0, 3'b000, 2'd0);
    send(32'hEEEE_0005, 5'd4, 1'b1, 1'b0, 3'b000, 2'd0);
    chk("mid_full", 64'(o_ready), 0);
    #2 i_reset = 1'b0;
    #1;
    chk("mid_we", 64'(o_rf_we), 0);
    chk("mid_data", 64'(o_rf_data), 0);
    chk("mid_empty", 64'(o_empty), 1);
    chk("mid_instret", o_instret, 0);
    chk("mid_ready", 64'(o_ready), 1);
    sb.delete();
    exp_ret = '0;
    step();
    chk("mid_hold_empty", 64'(o_empty), 1);
    i_reset = 1'b1;
    i_rf_ack = 1'b1;
    send(32'h0BAD_F00D, 5'd10, 1'b1, 1'b1, 3'b010, 2'd0);
    chk("post_rst_we", 64'(o_rf_we), 1);
    chk("post_rst_data", 64'(o_rf_data), 64'h0000_0000_0BAD_F00D);
    step();
    chk("post_rst_instret", o_instret, 1);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instret_q;
    #1;
    chk("wrap_pre", o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    send(32'h0, 5'd0, 1'b0, 1'b0, 3'b000, 2'd0);
    step();
    chk("wrap_zero", o_instret, 0);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter XLEN, default 32 (from rapid_pkg): datapath width.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_reset  input  1  asynchronous, active-low reset.
REQ-004 i_valid  input  1  memory-stage result valid (driven from memory-stage o_done).
REQ-005 o_ready  output  1  stage can accept a result this cycle.
REQ-006 i_wb_data  input  XLEN  memory-stage result (ALU result or raw load word).
REQ-007 i_rd  input  5  destination register index.
REQ-008 i_reg_write  input  1  instruction writes rd.
REQ-009 i_is_load  input  1  i_wb_data is a raw 32-bit load word needing alignment.
REQ-010 i_funct3  input  3  load size/sign code.
REQ-011 i_addr_lo  input  2  load address bits [1:0].
REQ-012 o_rf_we  output  1  register-file write request.
REQ-013 o_rf_rd  output  5  register-file write index.
REQ-014 o_rf_data  output  XLEN  register-file write data.
REQ-015 i_rf_ack  input  1  register file accepted the write this cycle.
REQ-016 o_instret  output  64  retired-instruction count.
REQ-017 o_empty  output  1  no results buffered.

Function
REQ-018 The block SHALL hold results in a 2-entry FIFO with states EMPTY, HALF, FULL.
REQ-019 o_ready SHALL equal (state != FULL), with no combinational path from i_valid or i_rf_ack.
REQ-020 A result SHALL be enqueued on any edge where i_valid && o_ready.
REQ-021 Alignment SHALL occur before enqueue, with shift = i_addr_lo*8 for bytes and i_addr_lo[1]*16 for halves: funct3 000 sign-extended byte; 100 zero-extended byte; 001 sign-extended half; 101 zero-extended half; 010 full word; any other funct3, or i_is_load=0, passes i_wb_data unchanged.
REQ-022 An entry with i_rd==0 SHALL be stored with reg_write forced to 0.
REQ-023 o_rf_we SHALL equal (head valid && head reg_write); o_rf_rd and o_rf_data SHALL present the head entry.
REQ-024 The head SHALL retire when (o_rf_we && i_rf_ack) or (head valid && !head reg_write); non-writing entries retire in one cycle without ack.
REQ-025 While o_rf_we=1 and i_rf_ack=0, o_rf_we, o_rf_rd and o_rf_data SHALL hold stable.
REQ-026 Latency: a result accepted at edge N SHALL drive o_rf_we in the cycle after edge N when the FIFO was EMPTY; if not EMPTY, it SHALL follow in FIFO order.
REQ-027 Transitions: EMPTY+enq->HALF; HALF+enq+retire->HALF; HALF+enq->FULL; HALF+retire->EMPTY; FULL+retire->HALF; no event->same state.
REQ-028 In FULL, i_valid SHALL be ignored and no entry overwritten.
REQ-029 o_instret SHALL increment by exactly 1 per retired entry, including non-writing entries, and wrap from 2^64-1 to 0.
REQ-030 o_empty SHALL be 1 exactly in state EMPTY.
REQ-031 When o_rf_we=0, o_rf_rd and o_rf_data SHALL be 0.

Reset
REQ-032 While i_reset=0, regardless of clock: state EMPTY, o_rf_we=0, o_rf_rd=0, o_rf_data=0, o_instret=0, o_empty=1, o_ready=1.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries with no write issued; a pending unacked write SHALL drop immediately.
REQ-034 The first enqueue SHALL be possible at the first rising edge after reset deassertion.

Verification
REQ-035 LB sign: i_wb_data=0x00008000, i_addr_lo=1, funct3=000, rd=5, i_rf_ack=1 -> next cycle o_rf_we=1, rd=5, data=0xFFFFFF80; o_instret=1.
REQ-036 LHU: i_wb_data=0xBEEF1234, i_addr_lo=2, funct3=101 -> o_rf_data=0x0000BEEF.
REQ-037 Backpressure: i_rf_ack=0, three back-to-back valid results -> first two accepted, o_ready=0 after second, third held off; data stable; raise ack -> writes occur in order, one per cycle.
REQ-038 rd=0 with i_reg_write=1 -> o_rf_we never asserts; o_instret increments by 1.
REQ-039 Reset mid-stall: FULL with ack=0, pulse i_reset low asynchronously -> o_rf_we=0 immediately, o_empty=1, o_instret=0.
REQ-040 Wrap: force o_instret=2^64-1, retire one -> o_instret=0.
